light_pen_detector: RTL and testbench

Receive-side counterpart of the LED matrix scan driver: it takes the raw photodiode output of the light pen, synchronizes and glitch-filters it, and correlates each qualified light pulse with the matrix scan position. The scan position is delay-compensated for optical and synchronizer latency. It outputs a one-cycle write strobe `we` with the decoded 3-bit row/column of the pixel under the pen, plus pen-present tracking, for the drawing/colour-select logic.

---
 rtl/light_pen_detector_pkg.sv | 29 ++
 rtl/light_pen_detector_pen_sync_filter.sv | 48 ++++
 rtl/light_pen_detector.sv | 116 +++++++++++
 tb/tb_light_pen_detector.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_pen_detector_pkg.sv
// Shared light-pen constants and the one-hot position decoder, also used by
// the colour selector.
package light_pen_detector_pkg;

  localparam int PEN_SYNC_STAGES = 2;
  localparam int PEN_LAG         = 3;
  localparam int PEN_MIN_HIGH    = 2;
  localparam int PEN_LOST_FRAMES = 4;

  // First pixel of a scan frame: row 0, column 0.
  localparam logic [15:0] FRAME_ORIGIN = 16'h0101;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } onehot_dec_t;

  // Binary index of a one-hot byte; valid is low for zero or multiple bits.
  function automatic onehot_dec_t onehot8_decode(input logic [7:0] vec);
    onehot_dec_t res;
    res.valid = (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);
    res.idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) res.idx = res.idx | 3'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/light_pen_detector_pen_sync_filter.sv
// Synchronizes the raw photodiode signal and emits one qual pulse per high run
// that lasts at least MIN_HIGH samples.
module pen_sync_filter
  import light_pen_detector_pkg::*;
#(
  parameter int SYNC_STAGES = PEN_SYNC_STAGES,
  parameter int MIN_HIGH    = PEN_MIN_HIGH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pen_i,
  output logic qual_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic [2:0]             run_q, run_d;
  logic                   armed_q, armed_d;
  logic                   p_sync;

  assign p_sync = sync_q[SYNC_STAGES-1];

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    run_d = 3'd0;
    if (p_sync) run_d = (run_q == 3'd7) ? run_q : run_q + 3'd1;
    // Reset zeros in the chain are not real samples; arm only on a genuine low.
    armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~p_sync);
  end

  assign qual_o = armed_q & p_sync & (run_q == 3'(MIN_HIGH - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      run_q   <= 3'd0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pen_i};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      run_q   <= run_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/light_pen_detector.sv
// Light pen receiver: correlates qualified pen pulses with the lag-compensated
// scan position and reports accepted hits plus pen-present tracking.
module light_pen_detector
  import light_pen_detector_pkg::*;
#(
  parameter int SYNC_STAGES = PEN_SYNC_STAGES,
  parameter int LAG         = PEN_LAG,
  parameter int MIN_HIGH    = PEN_MIN_HIGH,
  parameter int LOST_FRAMES = PEN_LOST_FRAMES,
  parameter int DEDUP       = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pen_in,
  input  logic [7:0] scan_row,
  input  logic [7:0] scan_col,
  output logic       we,
  output logic [2:0] hit_row,
  output logic [2:0] hit_col,
  output logic       pen_present,
  output logic [7:0] invalid_cnt
);

  logic        qual;
  logic [15:0] pos_live, pos_dly, pos_prev_q;
  onehot_dec_t row_dec, col_dec;
  logic        frame_start, det_valid, det_invalid, dup;
  logic        we_q, we_d;
  logic [2:0]  hit_row_q, hit_row_d, hit_col_q, hit_col_d;
  logic        present_q, present_d;
  logic [7:0]  invalid_q, invalid_d;
  logic [3:0]  frame_q, frame_d;

  pen_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_HIGH   (MIN_HIGH)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .pen_i (pen_in),
    .qual_o(qual)
  );

  assign pos_live = {scan_row, scan_col};

  generate
    if (LAG == 0) begin : g_no_lag
      assign pos_dly = pos_live;
    end else begin : g_lag
      logic [15:0] line_q [LAG];
      // NOTE: the delay line is reset so a stale pre-reset position can never pair with a pulse.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAG; i++) line_q[i] <= 16'd0;
        end else begin
          line_q[0] <= pos_live;
          for (int i = 1; i < LAG; i++) line_q[i] <= line_q[i-1];
        end
      end
      assign pos_dly = line_q[LAG-1];
    end
  endgenerate

  always_comb begin
    row_dec     = onehot8_decode(pos_dly[15:8]);
    col_dec     = onehot8_decode(pos_dly[7:0]);
    frame_start = (pos_dly == FRAME_ORIGIN) && (pos_prev_q != FRAME_ORIGIN);
    det_valid   = qual && row_dec.valid && col_dec.valid;
    det_invalid = qual && !(row_dec.valid && col_dec.valid);
    // Repeat of the last hit is only a duplicate while the pen is still tracked.
    dup         = (DEDUP != 0) && present_q &&
                  (row_dec.idx == hit_row_q) && (col_dec.idx == hit_col_q);

    we_d      = det_valid && !dup;
    hit_row_d = we_d ? row_dec.idx : hit_row_q;
    hit_col_d = we_d ? col_dec.idx : hit_col_q;
    invalid_d = (det_invalid && (invalid_q != 8'hFF)) ? invalid_q + 8'd1 : invalid_q;

    frame_d   = frame_q;
    present_d = present_q;
    if (det_valid) begin
      frame_d   = 4'd0;
      present_d = 1'b1;
    end else if (frame_start) begin
      if (frame_q != 4'hF) frame_d = frame_q + 4'd1;
      if (frame_d >= 4'(LOST_FRAMES)) present_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      hit_row_q  <= 3'd0;
      hit_col_q  <= 3'd0;
      present_q  <= 1'b0;
      invalid_q  <= 8'd0;
      frame_q    <= 4'd0;
      pos_prev_q <= 16'd0;
    end else begin
      we_q       <= we_d;
      hit_row_q  <= hit_row_d;
      hit_col_q  <= hit_col_d;
      present_q  <= present_d;
      invalid_q  <= invalid_d;
      frame_q    <= frame_d;
      pos_prev_q <= pos_dly;
    end
  end

  assign we          = we_q;
  assign hit_row     = hit_row_q;
  assign hit_col     = hit_col_q;
  assign pen_present = present_q;
  assign invalid_cnt = invalid_q;

endmodule

// File: tb/tb_light_pen_detector.sv
// Bench for light_pen_detector: directed table and sequences plus random
// traffic, all checked against a history-based behavioural model.
module tb_light_pen_detector;

  localparam int S     = 2;
  localparam int LAG   = 3;
  localparam int M     = 2;
  localparam int LOST  = 4;
  localparam int DEDUP = 1;
  localparam int HIST  = 16384;

  typedef struct {
    logic       pen;
    logic [7:0] row;
    logic [7:0] col;
    logic       we;
    logic [2:0] hr;
    logic [2:0] hc;
    logic       present;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       pen_in = 1'b0;
  logic [7:0] scan_row = 8'd0;
  logic [7:0] scan_col = 8'd0;
  logic       we;
  logic [2:0] hit_row, hit_col;
  logic       pen_present;
  logic [7:0] invalid_cnt;

  light_pen_detector #(
    .SYNC_STAGES(S),
    .LAG        (LAG),
    .MIN_HIGH   (M),
    .LOST_FRAMES(LOST),
    .DEDUP      (DEDUP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pen_in     (pen_in),
    .scan_row   (scan_row),
    .scan_col   (scan_col),
    .we         (we),
    .hit_row    (hit_row),
    .hit_col    (hit_col),
    .pen_present(pen_present),
    .invalid_cnt(invalid_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: full input history since reset plus the architectural outputs.
  logic        pen_h [HIST];
  logic [15:0] pos_h [HIST];
  int          cyc;
  bit          m_seen_low, m_we, m_present;
  int          m_hr, m_hc, m_inv, m_fcnt;
  int          we_seen;
  vec_t        tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic psync_at(input int k);
    return (k < S) ? 1'b0 : pen_h[k-S];
  endfunction

  function automatic logic [15:0] dpos_at(input int k);
    return (k - LAG < 0) ? 16'd0 : pos_h[k-LAG];
  endfunction

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] gen(input int t);
    logic [7:0] r, c;
    r = 8'd1 << ((t >> 3) & 7);
    c = 8'd1 << (t & 7);
    return {r, c};
  endfunction

  // Decide what the outputs must be in cycle cyc+1 from the history up to cyc.
  task automatic model_update();
    bit          qual, det, fs;
    logic [15:0] dp;
    qual = m_seen_low;
    for (int j = 0; j < M; j++) if (!psync_at(cyc - j)) qual = 0;
    if (psync_at(cyc - M)) qual = 0;
    if (cyc >= S && !pen_h[cyc-S]) m_seen_low = 1;
    dp   = dpos_at(cyc);
    fs   = (dp == 16'h0101) && (dpos_at(cyc - 1) != 16'h0101);
    m_we = 0;
    det  = 0;
    if (qual) begin
      if ($countones(dp[15:8]) != 1 || $countones(dp[7:0]) != 1) begin
        if (m_inv < 255) m_inv++;
      end else begin
        det = 1;
        if (!(DEDUP != 0 && m_present && idx_of(dp[15:8]) == m_hr && idx_of(dp[7:0]) == m_hc)) begin
          m_we = 1;
          m_hr = idx_of(dp[15:8]);
          m_hc = idx_of(dp[7:0]);
        end
      end
    end
    if (det) begin
      m_fcnt    = 0;
      m_present = 1;
    end else if (fs) begin
      if (m_fcnt < 15) m_fcnt++;
      if (m_fcnt >= LOST) m_present = 0;
    end
  endtask

  task automatic step(input logic p, input logic [7:0] r, input logic [7:0] c);
    chk("we", we, m_we);
    chk("hit_row", hit_row, m_hr);
    chk("hit_col", hit_col, m_hc);
    chk("pen_present", pen_present, m_present);
    chk("invalid_cnt", invalid_cnt, m_inv);
    if (we === 1'b1) we_seen++;
    if (cyc >= HIST) begin
      $display("FAIL history: cycle %0d exceeds model depth %0d", cyc, HIST);
      $fatal(1);
    end
    pen_in   = p;
    scan_row = r;
    scan_col = c;
    pen_h[cyc] = p;
    pos_h[cyc] = {r, c};
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic p);
    rst_n  = 1'b0;
    pen_in = p;
    #2;
    chk("rst_we", we, 0);
    chk("rst_hit_row", hit_row, 0);
    chk("rst_hit_col", hit_col, 0);
    chk("rst_present", pen_present, 0);
    chk("rst_invalid", invalid_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    cyc        = 0;
    m_seen_low = 0;
    m_we       = 0;
    m_present  = 0;
    m_hr       = 0;
    m_hc       = 0;
    m_inv      = 0;
    m_fcnt     = 0;
    we_seen    = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] r, c;
    logic       p;
    int         run_left;

    for (int k = 0; k < 24; k++) begin
      tbl[k].pen     = (k >= 11 && k <= 20);
      tbl[k].row     = (k >= 10) ? 8'h04 : 8'h00;
      tbl[k].col     = (k >= 10) ? 8'h10 : 8'h00;
      tbl[k].we      = (k == 15);
      tbl[k].hr      = (k >= 15) ? 3'd2 : 3'd0;
      tbl[k].hc      = (k >= 15) ? 3'd4 : 3'd0;
      tbl[k].present = (k >= 15);
    end

    #1;
    do_reset(1'b0);

    // Basic hit: single strobe at cycle 15 with row 2 / col 4.
    for (int k = 0; k < 24; k++) begin
      chk("tbl_we", we, tbl[k].we);
      chk("tbl_hit_row", hit_row, tbl[k].hr);
      chk("tbl_hit_col", hit_col, tbl[k].hc);
      chk("tbl_present", pen_present, tbl[k].present);
      step(tbl[k].pen, tbl[k].row, tbl[k].col);
    end
    chk("tbl_we_count", we_seen, 1);

    // One-cycle pulse is filtered out.
    we_seen = 0;
    step(1'b1, 8'h04, 8'h10);
    repeat (10) step(1'b0, 8'h04, 8'h10);
    chk("short_we_count", we_seen, 0);
    chk("short_invalid", invalid_cnt, 0);

    // Non-one-hot positions are counted and saturate.
    do_reset(1'b0);
    repeat (4) step(1'b0, 8'h04, 8'h00);
    repeat (2) step(1'b1, 8'h04, 8'h00);
    repeat (6) step(1'b0, 8'h04, 8'h00);
    chk("inv_col00", invalid_cnt, 1);
    repeat (2) step(1'b1, 8'h04, 8'h18);
    repeat (6) step(1'b0, 8'h04, 8'h18);
    chk("inv_col18", invalid_cnt, 2);
    for (int k = 0; k < 300; k++) begin
      repeat (2) step(1'b1, 8'h04, 8'h00);
      repeat (2) step(1'b0, 8'h04, 8'h00);
    end
    repeat (6) step(1'b0, 8'h04, 8'h00);
    chk("inv_saturate", invalid_cnt, 255);
    chk("inv_no_we", we_seen, 0);

    // Dedup over three frames, presence loss after LOST frames, re-acceptance.
    do_reset(1'b0);
    for (int t = 0; t < 3 * 64; t++) begin
      {r, c} = gen(t);
      step((t % 64) == 29 || (t % 64) == 30, r, c);
    end
    chk("dedup_we_count", we_seen, 1);
    chk("dedup_hit_row", hit_row, 3);
    chk("dedup_hit_col", hit_col, 5);
    for (int t = 3 * 64; t < 6 * 64; t++) begin
      {r, c} = gen(t);
      step(1'b0, r, c);
    end
    chk("present_three_frames", pen_present, 1);
    for (int t = 6 * 64; t < 7 * 64; t++) begin
      {r, c} = gen(t);
      step(1'b0, r, c);
    end
    chk("present_lost", pen_present, 0);
    we_seen = 0;
    for (int t = 7 * 64; t < 8 * 64; t++) begin
      {r, c} = gen(t);
      step((t % 64) == 29 || (t % 64) == 30, r, c);
    end
    chk("rearm_we_count", we_seen, 1);
    chk("rearm_present", pen_present, 1);

    // Two different pixels in one frame give two strobes.
    we_seen = 0;
    repeat (3) step(1'b0, 8'h02, 8'h02);
    repeat (2) step(1'b1, 8'h02, 8'h02);
    repeat (6) step(1'b0, 8'h02, 8'h02);
    chk("two_first_col", hit_col, 1);
    chk("two_first_row", hit_row, 1);
    repeat (2) step(1'b0, 8'h02, 8'h04);
    repeat (2) step(1'b1, 8'h02, 8'h04);
    repeat (6) step(1'b0, 8'h02, 8'h04);
    chk("two_second_col", hit_col, 2);
    chk("two_we_count", we_seen, 2);

    // Reset during a lit pen: no hit until the pen has gone dark once.
    repeat (3) step(1'b1, 8'h02, 8'h04);
    do_reset(1'b1);
    repeat (12) step(1'b1, 8'h02, 8'h04);
    chk("rst_lit_no_we", we_seen, 0);
    repeat (3) step(1'b0, 8'h02, 8'h04);
    repeat (4) step(1'b1, 8'h02, 8'h04);
    repeat (6) step(1'b0, 8'h02, 8'h04);
    chk("rst_relit_we", we_seen, 1);
    chk("rst_relit_col", hit_col, 2);

    // Random pen runs over fast, slow and corrupted scans, with dark stretches.
    do_reset(1'b0);
    p        = 1'b0;
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        p        = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 6);
      end
      run_left--;
      {r, c} = (((i / 500) % 2) == 1) ? gen(i / 4) : gen(i);
      if ($urandom_range(0, 9) == 0) begin
        r = 8'($urandom);
        c = 8'($urandom);
      end
      step((((i / 500) % 3) == 2) ? 1'b0 : p, r, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
